// File: rtl/pwm_sequencer.sv
// 16-channel LED PWM with a shared prescaler/phase counter and per-channel static or ramp duty.
// Latency: led registered one cycle after the phase/duty state; duty writes commit at the next period boundary.
// Backpressure: wr_ready drops only in the boundary cycle and during reset; a held request is taken the cycle after.
module pwm_sequencer #(
   parameter int unsigned PRESCALE = 390,
   parameter logic [7:0]  STEP     = 8'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] sw,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [3:0]  wr_ch,
   input  logic        wr_mode,
   input  logic [7:0]  wr_duty,
   output logic [15:0] led,
   output logic        period_tick
);

   localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

   // Shared timebase
   logic [15:0] pre_q, pre_d;
   logic [7:0]  phase_q, phase_d;
   logic        boundary;

   // Per-channel active state (dir: 0 = up, 1 = down) and staged writes
   logic [15:0][7:0] duty_q, duty_d;
   logic [15:0]      mode_q, mode_d;
   logic [15:0]      dir_q, dir_d;
   logic [15:0]      pending_q, pending_d;
   logic [15:0][7:0] shd_duty_q, shd_duty_d;
   logic [15:0]      shd_mode_q, shd_mode_d;

   // Registered outputs
   logic [15:0] led_q, led_d;
   logic        tick_q, tick_d;

   logic        wr_fire;
   logic [8:0]  sum9;
   logic [8:0]  diff9;

   // Prescaler and phase counter; boundary is the last prescale cycle of phase 255
   always_comb begin
      pre_d    = pre_q + 16'd1;
      phase_d  = phase_q;
      boundary = 1'b0;
      if (pre_q == PRE_MAX) begin
         pre_d   = 16'd0;
         phase_d = phase_q + 8'd1;
         if (phase_q == 8'hFF) begin
            boundary = 1'b1;
         end
      end
      tick_d = boundary;
   end

   assign wr_ready = !rst && !boundary;
   assign wr_fire  = wr_valid && wr_ready;

   // Channel update: commit pending shadows or step ramps at the boundary, capture writes otherwise
   always_comb begin
      duty_d     = duty_q;
      mode_d     = mode_q;
      dir_d      = dir_q;
      pending_d  = pending_q;
      shd_duty_d = shd_duty_q;
      shd_mode_d = shd_mode_q;
      sum9       = 9'd0;
      diff9      = 9'd0;
      for (int i = 0; i < 16; i++) begin
         if (boundary) begin
            if (pending_q[i]) begin
               // A fresh write always wins over the ramp step of this period
               duty_d[i]    = shd_duty_q[i];
               mode_d[i]    = shd_mode_q[i];
               dir_d[i]     = 1'b0;
               pending_d[i] = 1'b0;
            end else if (mode_q[i]) begin
               sum9  = {1'b0, duty_q[i]} + {1'b0, STEP};
               diff9 = {1'b0, duty_q[i]} - {1'b0, STEP};
               if (!dir_q[i]) begin
                  if (sum9 >= 9'd255) begin
                     duty_d[i] = 8'hFF;
                     dir_d[i]  = 1'b1;
                  end else begin
                     duty_d[i] = sum9[7:0];
                  end
               end else begin
                  // diff9[8] set means the subtraction went below zero
                  if (diff9[8] || (diff9 == 9'd0)) begin
                     duty_d[i] = 8'h00;
                     dir_d[i]  = 1'b0;
                  end else begin
                     duty_d[i] = diff9[7:0];
                  end
               end
            end
         end
         // wr_ready is low on the boundary, so a capture never collides with a commit
         if (wr_fire && (wr_ch == 4'(i))) begin
            shd_duty_d[i] = wr_duty;
            shd_mode_d[i] = wr_mode;
            pending_d[i]  = 1'b1;
         end
      end
   end

   // PWM compare against the current phase, masked by the live switch inputs
   always_comb begin
      led_d = '0;
      for (int i = 0; i < 16; i++) begin
         led_d[i] = (phase_q < duty_q[i]) & sw[i];
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q      <= '0;
         phase_q    <= '0;
         duty_q     <= '0;
         mode_q     <= '0;
         dir_q      <= '0;
         pending_q  <= '0;
         shd_duty_q <= '0;
         shd_mode_q <= '0;
         led_q      <= '0;
         tick_q     <= 1'b0;
      end else begin
         pre_q      <= pre_d;
         phase_q    <= phase_d;
         duty_q     <= duty_d;
         mode_q     <= mode_d;
         dir_q      <= dir_d;
         pending_q  <= pending_d;
         shd_duty_q <= shd_duty_d;
         shd_mode_q <= shd_mode_d;
         led_q      <= led_d;
         tick_q     <= tick_d;
      end
   end

   assign led         = led_q;
   assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer with PRESCALE=2 (512-cycle period) and STEP=4.
// Latency: outputs sampled on the falling edge; per-period statistics snapshot on each period_tick.
// Backpressure: writes hold wr_valid until wr_ready is seen high, with a bounded wait.
module tb_pwm_sequencer;

   logic        clk;
   logic        rst;
   logic [15:0] sw;
   logic        wr_valid;
   logic        wr_ready;
   logic [3:0]  wr_ch;
   logic        wr_mode;
   logic [7:0]  wr_duty;
   logic [15:0] led;
   logic        period_tick;

   pwm_sequencer #(.PRESCALE(2), .STEP(8'd4)) dut (
      .clk        (clk),
      .rst        (rst),
      .sw         (sw),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_ch      (wr_ch),
      .wr_mode    (wr_mode),
      .wr_duty    (wr_duty),
      .led        (led),
      .period_tick(period_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nasrt = 0;
   int nfail = 0;

   // Running statistics for the current period, snapshotted on each tick
   int hi[16];
   int last_hi[16];
   int plen, last_plen;
   int rdy_lo, last_rdy_lo;
   bit seen_tick;
   bit tick_at_acc;
   int waited;

   task automatic chk(input string tag, input int obs, input int exp);
      nasrt++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      for (int i = 0; i < 16; i++) hi[i] = 0;
      plen   = 0;
      rdy_lo = 0;
   endtask

   task automatic step();
      @(negedge clk);
      plen++;
      for (int i = 0; i < 16; i++) if (led[i]) hi[i]++;
      if (!wr_ready) rdy_lo++;
      if (period_tick) begin
         last_hi     = hi;
         last_plen   = plen;
         last_rdy_lo = rdy_lo;
         clear_stats();
         seen_tick = 1'b1;
      end
   endtask

   task automatic wait_tick();
      int n;
      n = 0;
      seen_tick = 1'b0;
      while (!seen_tick && n < 2000) begin
         step();
         n++;
      end
      chk("tick_wait", int'(seen_tick), 1);
   endtask

   task automatic do_write(input logic [3:0] ch, input logic m, input logic [7:0] d);
      wr_ch    = ch;
      wr_mode  = m;
      wr_duty  = d;
      wr_valid = 1'b1;
      waited   = 0;
      while (!wr_ready && waited < 1000) begin
         step();
         waited++;
      end
      tick_at_acc = period_tick;
      step();
      wr_valid = 1'b0;
   endtask

   function automatic int sum_hi(input int skip);
      int s;
      s = 0;
      for (int i = 0; i < 16; i++) if (i != skip) s += last_hi[i];
      return s;
   endfunction

   // Hand-derived ramp duty for the k-th full period after a ramp commit at 250
   function automatic int ramp_duty(input int k);
      if (k == 0) return 250;
      if (k == 1) return 254;
      if (k <= 65) return 255 - 4 * (k - 2);
      if (k == 66) return 0;
      return 4;
   endfunction

   initial begin
      rst      = 1'b1;
      sw       = 16'hFFFF;
      wr_valid = 1'b0;
      wr_ch    = 4'd0;
      wr_mode  = 1'b0;
      wr_duty  = 8'd0;
      clear_stats();
      last_plen   = 0;
      last_rdy_lo = 0;
      seen_tick   = 1'b0;
      tick_at_acc = 1'b0;
      waited      = 0;
      for (int i = 0; i < 16; i++) last_hi[i] = 0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_led", int'(led), 0);
      chk("rst_tick", int'(period_tick), 0);
      chk("rst_ready", int'(wr_ready), 0);
      rst = 1'b0;
      clear_stats();
      #1;
      chk("release_ready", int'(wr_ready), 1);

      // Idle periods: no LEDs, tick every 512 cycles, ready low once per period
      for (int p = 0; p < 2; p++) begin
         wait_tick();
         chk("idle_plen", last_plen, 512);
         chk("idle_rdy_lo", last_rdy_lo, 1);
         chk("idle_led", sum_hi(-1), 0);
      end

      // Static write to ch3 mid-period: not visible until the boundary
      repeat (100) step();
      do_write(4'd3, 1'b0, 8'd128);
      chk("ch3_wait", waited, 0);
      wait_tick();
      chk("ch3_before", last_hi[3], 0);
      wait_tick();
      chk("ch3_after", last_hi[3], 256);
      chk("ch3_others", sum_hi(3), 0);

      // ch0 at duty 255 with a 100-cycle sw mask window
      repeat (50) step();
      do_write(4'd0, 1'b0, 8'd255);
      wait_tick();
      chk("ch0_before", last_hi[0], 0);
      repeat (200) step();
      chk("ch0_on", int'(led[0]), 1);
      sw[0] = 1'b0;
      step();
      chk("ch0_mask_first", int'(led[0]), 0);
      repeat (99) step();
      chk("ch0_mask_last", int'(led[0]), 0);
      sw[0] = 1'b1;
      step();
      chk("ch0_unmask", int'(led[0]), 1);
      wait_tick();
      chk("ch0_count", last_hi[0], 410);
      chk("ch3_steady", last_hi[3], 256);
      wait_tick();
      chk("ch0_full", last_hi[0], 510);

      // Ramp on ch5 starting at 250: up to 255, down to 3, 0, then back up
      repeat (10) step();
      do_write(4'd5, 1'b1, 8'd250);
      wait_tick();
      chk("ch5_before", last_hi[5], 0);
      for (int k = 0; k < 68; k++) begin
         wait_tick();
         chk($sformatf("ramp_p%0d", k), last_hi[5], 2 * ramp_duty(k));
      end

      // Write presented on the boundary: refused there, accepted on the tick cycle
      repeat (511) step();
      chk("rdy_on_b", int'(wr_ready), 0);
      do_write(4'd7, 1'b0, 8'd40);
      chk("b_wait", waited, 1);
      chk("b_acc_tick", int'(tick_at_acc), 1);
      repeat (20) step();
      do_write(4'd7, 1'b0, 8'd90);
      chk("ch7_second_wait", waited, 0);
      wait_tick();
      chk("ch7_not_yet", last_hi[7], 0);
      wait_tick();
      chk("ch7_last_wins", last_hi[7], 180);

      // Mid-period reset with ch2 pending and ch5 ramping
      repeat (100) step();
      do_write(4'd2, 1'b0, 8'd200);
      repeat (50) step();
      rst = 1'b1;
      step();
      chk("midrst_led", int'(led), 0);
      chk("midrst_ready", int'(wr_ready), 0);
      chk("midrst_tick", int'(period_tick), 0);
      rst = 1'b0;
      clear_stats();
      wait_tick();
      chk("post_rst_plen", last_plen, 512);
      chk("post_rst_led1", sum_hi(-1), 0);
      wait_tick();
      chk("post_rst_led2", sum_hi(-1), 0);
      chk("post_rst_ch2", last_hi[2], 0);
      chk("post_rst_ch5", last_hi[5], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
      $finish;
   end

endmodule
